// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store byte-lane unit.
//   - funct3 codes for RV32I loads/stores (F3_B, F3_H, F3_W, F3_BU, F3_HU)
//   - FSM state encoding (ST_IDLE, ST_RMW)
//   - lane_merge(): inserts store data into a RAM word for SB/SH
//   - small helpers for funct3 legality, misalignment and offset alignment
// Optional feature macro used by the importing files: LSU_MISALIGN_TRAP_EN.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RMW  = 1'b1
    } lsu_state_e;

    // Replace the byte or halfword lane selected by offset with the low
    // bits of wdata; W replaces the whole word, anything else leaves it.
    function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                               input logic [31:0] wdata,
                                               input logic [1:0]  offset,
                                               input logic [2:0]  func3);
        logic [31:0] res;
        res = word;
        case (func3)
            F3_B: begin
                case (offset)
                    2'd0:    res[7:0]   = wdata[7:0];
                    2'd1:    res[15:8]  = wdata[7:0];
                    2'd2:    res[23:16] = wdata[7:0];
                    default: res[31:24] = wdata[7:0];
                endcase
            end
            F3_H: begin
                if (offset[1]) res[31:16] = wdata[15:0];
                else           res[15:0]  = wdata[15:0];
            end
            F3_W:    res = wdata;
            default: res = word;
        endcase
        return res;
    endfunction

    // Stores only come in B/H/W flavours; loads additionally have BU/HU.
    function automatic logic f3_legal(input logic [2:0] func3,
                                      input logic       is_store);
        logic ok;
        ok = (func3 == F3_B) || (func3 == F3_H) || (func3 == F3_W);
        if (!is_store) ok = ok || (func3 == F3_BU) || (func3 == F3_HU);
        return ok;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] func3,
                                           input logic [1:0] offset);
        logic mis;
        case (func3)
            F3_H, F3_HU: mis = offset[0];
            F3_W:        mis = (offset != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Force the low address bits to the natural alignment of the access.
    function automatic logic [1:0] align_offset(input logic [2:0] func3,
                                                input logic [1:0] offset);
        logic [1:0] off;
        case (func3)
            F3_H, F3_HU: off = {offset[1], 1'b0};
            F3_W:        off = 2'b00;
            default:     off = offset;
        endcase
        return off;
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// lsu_load_extend: combinational load-data lane select and extension.
// Ports:
//   mem_dout  in  32  raw RAM word
//   offset    in  2   byte offset inside the word (already aligned for H/W)
//   func3     in  3   RV32I load funct3
//   ext_data  out 32  sign/zero-extended result; 0 for an illegal funct3
module lsu_load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] mem_dout,
    input  logic [1:0]  offset,
    input  logic [2:0]  func3,
    output logic [31:0] ext_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = mem_dout[{offset, 3'b000} +: 8];
        half_sel = offset[1] ? mem_dout[31:16] : mem_dout[15:0];
        case (func3)
            F3_B:    ext_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   ext_data = {24'h0, byte_sel};
            F3_H:    ext_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   ext_data = {16'h0, half_sel};
            F3_W:    ext_data = mem_dout;
            default: ext_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/lsu_byte_lane.sv
// lsu_byte_lane: RV32I load/store unit in front of a word-wide synchronous
// data RAM whose read data appears one cycle after the address edge.
//   Loads : address driven in the accept cycle, extended data next cycle.
//   SW    : written straight through in the accept cycle.
//   SB/SH : accept cycle reads the word, next cycle (ST_RMW, busy=1)
//           writes the merged word back.
// Ports:
//   clock, clear (async, active-low)
//   req_valid/req_write/req_func3/req_addr/req_wdata : request from MEM stage
//   busy      : request cannot be accepted this cycle
//   rsp_valid/rsp_rdata : load result, rdata is 0 when rsp_valid is 0
//   err       : one-cycle fault pulse (only with LSU_MISALIGN_TRAP_EN)
//   mem_addr/mem_wren/mem_din/mem_dout : RAM port
// Optional feature: define LSU_MISALIGN_TRAP_EN to trap misaligned and
// illegal-funct3 requests instead of silently aligning them.
// Handshake: a request transfers in any cycle with req_valid=1 and busy=0;
// while busy=1 the requester holds the request unchanged.
module lsu_byte_lane
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [2:0]            req_func3,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  busy,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wren,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout
);

    lsu_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] rmw_addr_q, rmw_addr_d;
    logic [1:0]            rmw_off_q, rmw_off_d;
    logic [2:0]            rmw_f3_q, rmw_f3_d;
    logic [31:0]           rmw_wdata_q, rmw_wdata_d;

    // Load response is a flag beside the FSM so a response can overlap
    // the acceptance of the next request.
    logic                  ld_pend_q, ld_pend_d;
    logic [1:0]            ld_off_q, ld_off_d;
    logic [2:0]            ld_f3_q, ld_f3_d;
    logic                  ld_zero_q, ld_zero_d;

    logic [ADDR_WIDTH-1:0] req_word;
    logic [1:0]            req_off;
    logic                  req_bad;
    logic [31:0]           ext_data;
    logic                  unused_addr_hi;

    // Byte-address bits above the RAM range are ignored (address wraps).
    assign req_word       = req_addr[ADDR_WIDTH+1:2];
    assign req_off        = align_offset(req_func3, req_addr[1:0]);
    assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH+2];

`ifdef LSU_MISALIGN_TRAP_EN
    assign req_bad = !f3_legal(req_func3, req_write) ||
                     is_misaligned(req_func3, req_addr[1:0]);
`else
    assign req_bad = !f3_legal(req_func3, req_write);
`endif

    assign busy = (state_q == ST_RMW);

    always_comb begin
        state_d     = state_q;
        rmw_addr_d  = rmw_addr_q;
        rmw_off_d   = rmw_off_q;
        rmw_f3_d    = rmw_f3_q;
        rmw_wdata_d = rmw_wdata_q;
        ld_pend_d   = 1'b0;
        ld_off_d    = ld_off_q;
        ld_f3_d     = ld_f3_q;
        ld_zero_d   = 1'b0;
        mem_addr    = '0;
        mem_wren    = 1'b0;
        mem_din     = '0;
        case (state_q)
            ST_RMW: begin
                // mem_dout holds the word read in the accept cycle.
                mem_addr = rmw_addr_q;
                mem_wren = 1'b1;
                mem_din  = lane_merge(mem_dout, rmw_wdata_q, rmw_off_q, rmw_f3_q);
                state_d  = ST_IDLE;
            end
            default: begin
                // Nothing is accepted while clear is asserted.
                if (req_valid && clear) begin
                    mem_addr = req_word;
                    if (!req_write) begin
                        ld_pend_d = 1'b1;
                        ld_off_d  = req_off;
                        ld_f3_d   = req_func3;
                        ld_zero_d = req_bad;
                    end else if (!req_bad) begin
                        if (req_func3 == F3_W) begin
                            mem_wren = 1'b1;
                            mem_din  = req_wdata;
                        end else begin
                            state_d     = ST_RMW;
                            rmw_addr_d  = req_word;
                            rmw_off_d   = req_off;
                            rmw_f3_d    = req_func3;
                            rmw_wdata_d = req_wdata;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q     <= ST_IDLE;
            rmw_addr_q  <= '0;
            rmw_off_q   <= 2'b00;
            rmw_f3_q    <= 3'b000;
            rmw_wdata_q <= 32'h0;
            ld_pend_q   <= 1'b0;
            ld_off_q    <= 2'b00;
            ld_f3_q     <= 3'b000;
            ld_zero_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rmw_addr_q  <= rmw_addr_d;
            rmw_off_q   <= rmw_off_d;
            rmw_f3_q    <= rmw_f3_d;
            rmw_wdata_q <= rmw_wdata_d;
            ld_pend_q   <= ld_pend_d;
            ld_off_q    <= ld_off_d;
            ld_f3_q     <= ld_f3_d;
            ld_zero_q   <= ld_zero_d;
        end
    end

    lsu_load_extend u_extend (
        .mem_dout (mem_dout),
        .offset   (ld_off_q),
        .func3    (ld_f3_q),
        .ext_data (ext_data)
    );

    assign rsp_valid = ld_pend_q;
    assign rsp_rdata = (ld_pend_q && !ld_zero_q) ? ext_data : '0;

`ifdef LSU_MISALIGN_TRAP_EN
    logic err_q, err_d;

    always_comb begin
        err_d = 1'b0;
        if (state_q == ST_IDLE && req_valid && clear) err_d = req_bad;
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
